// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states and the scoreboard-slot layout.
package hazard_ctrl_pkg;

   // Forwarding-select encoding driven onto fwd_a / fwd_b
   localparam int unsigned FWD_W     = 2;
   localparam logic [1:0]  FWD_RF    = 2'b00;
   localparam logic [1:0]  FWD_EXMEM = 2'b01;
   localparam logic [1:0]  FWD_MEMWB = 2'b10;

   // Controller sequencing states
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2
   } hz_state_t;

   // Scoreboard slot layout {wr, rd, is_load}; the rd field follows REG_W
   localparam int unsigned SB_REG_W  = 5;
   localparam int unsigned SB_META_W = 2;

   typedef struct packed {
      logic                wr;
      logic [SB_REG_W-1:0] rd;
      logic                is_load;
   } sb_slot_t;

   localparam int unsigned SB_SLOT_W = $bits(sb_slot_t);

   // Slot width for an arbitrary register-index width
   function automatic int unsigned sb_slot_w(input int unsigned reg_w);
      return reg_w + SB_META_W;
   endfunction

endpackage

// File: rtl/hazard_sb_slot.sv
// One registered scoreboard slot: holds while the pipe is frozen,
// loads zero on clear, otherwise captures the incoming entry.
module hazard_sb_slot
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned W = SB_SLOT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_hold,
   input  logic         i_clear,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Slot register with synchronous reset, hold and clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (!i_hold) begin
         r_q <= i_clear ? '0 : i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls, jump
// squashes, data-memory freezes and operand forwarding selects.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             id_reg_wrenable,
   input  logic [REG_W-1:0] id_write_reg,
   input  logic             id_mem_to_reg,
   input  logic             ex_is_jump,
   input  logic             mem_busy,
   output logic             should_stall,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             ifid_flush,
   output logic             pipe_freeze,
   output logic [FWD_W-1:0] fwd_a,
   output logic [FWD_W-1:0] fwd_b
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] freeze_count
`endif
);

   localparam int unsigned SLOT_W = sb_slot_w(REG_W);

   hz_state_t          r_state;
   hz_state_t          w_next;

   logic [SLOT_W-1:0]  w_ex_q;
   logic [SLOT_W-1:0]  w_mem_q;
   logic [SLOT_W-1:0]  w_id_entry;
   logic               w_ex_wr;
   logic [REG_W-1:0]   w_ex_rd;
   logic               w_ex_ld;
   logic               w_mem_wr;
   logic [REG_W-1:0]   w_mem_rd;
   logic               w_unused_mem_ld;

   logic               w_ex_a;
   logic               w_ex_b;
   logic               w_mem_a;
   logic               w_mem_b;
   logic               w_load_use;

   logic               w_stall;
   logic               w_pc_hold;
   logic               w_ifid_hold;
   logic               w_flush;
   logic               w_freeze;
   logic               w_lu_stall;
   logic [FWD_W-1:0]   w_fwd_a;
   logic [FWD_W-1:0]   w_fwd_b;
   logic               w_ex_clear;

   // Slot fields; MEM-stage load flag is not needed once the load reaches MEM/WB
   assign w_ex_wr         = w_ex_q[SLOT_W-1];
   assign w_ex_rd         = w_ex_q[SLOT_W-2:1];
   assign w_ex_ld         = w_ex_q[0];
   assign w_mem_wr        = w_mem_q[SLOT_W-1];
   assign w_mem_rd        = w_mem_q[SLOT_W-2:1];
   assign w_unused_mem_ld = w_mem_q[0];

   // Source-operand matches against the EX and MEM slots; x0 never matches
   assign w_ex_a  = w_ex_wr  && (w_ex_rd  == id_rs1) && (id_rs1 != '0) && id_uses_rs1;
   assign w_ex_b  = w_ex_wr  && (w_ex_rd  == id_rs2) && (id_rs2 != '0) && id_uses_rs2;
   assign w_mem_a = w_mem_wr && (w_mem_rd == id_rs1) && (id_rs1 != '0) && id_uses_rs1;
   assign w_mem_b = w_mem_wr && (w_mem_rd == id_rs2) && (id_rs2 != '0) && id_uses_rs2;

   assign w_load_use = (w_ex_a || w_ex_b) && w_ex_ld;

   // Forwarding selects: an ALU result in EX wins over anything in MEM
   always_comb begin
      w_fwd_a = FWD_RF;
      w_fwd_b = FWD_RF;
      if (w_ex_a && !w_ex_ld) begin
         w_fwd_a = FWD_EXMEM;
      end else if (w_mem_a) begin
         w_fwd_a = FWD_MEMWB;
      end
      if (w_ex_b && !w_ex_ld) begin
         w_fwd_b = FWD_EXMEM;
      end else if (w_mem_b) begin
         w_fwd_b = FWD_MEMWB;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and control outputs; MEM_WAIT exits through the RUN decision
   always_comb begin
      w_next      = r_state;
      w_stall     = 1'b0;
      w_pc_hold   = 1'b0;
      w_ifid_hold = 1'b0;
      w_flush     = 1'b0;
      w_freeze    = 1'b0;
      w_lu_stall  = 1'b0;
      case (r_state)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_busy) begin
               w_freeze    = 1'b1;
               w_pc_hold   = 1'b1;
               w_ifid_hold = 1'b1;
               w_stall     = 1'b1;
               w_next      = ST_MEM_WAIT;
            end else if (ex_is_jump) begin
               w_flush = 1'b1;
               w_stall = 1'b1;
               w_next  = ST_FLUSH;
            end else if (w_load_use) begin
               w_pc_hold   = 1'b1;
               w_ifid_hold = 1'b1;
               w_stall     = 1'b1;
               w_lu_stall  = 1'b1;
               w_next      = ST_RUN;
            end else begin
               w_next = ST_RUN;
            end
         end
         ST_FLUSH: begin
            w_flush = 1'b1;
            w_stall = 1'b1;
            if (mem_busy) begin
               w_freeze    = 1'b1;
               w_pc_hold   = 1'b1;
               w_ifid_hold = 1'b1;
               w_next      = ST_MEM_WAIT;
            end else begin
               w_next = ST_RUN;
            end
         end
         default: begin
            w_next = ST_RUN;
         end
      endcase
      // Reset dominates every event: all controls and selects read as zero
      if (!rst_n) begin
         w_stall     = 1'b0;
         w_pc_hold   = 1'b0;
         w_ifid_hold = 1'b0;
         w_flush     = 1'b0;
         w_freeze    = 1'b0;
         w_lu_stall  = 1'b0;
      end
   end

   assign should_stall = w_stall;
   assign pc_hold      = w_pc_hold;
   assign ifid_hold    = w_ifid_hold;
   assign ifid_flush   = w_flush;
   assign pipe_freeze  = w_freeze;
   assign fwd_a        = rst_n ? w_fwd_a : FWD_RF;
   assign fwd_b        = rst_n ? w_fwd_b : FWD_RF;

   // A bubble or an empty ID stage enters EX as an all-zero entry
   assign w_id_entry = {id_reg_wrenable, id_write_reg, id_mem_to_reg};
   assign w_ex_clear = w_stall || !id_valid;

   hazard_sb_slot #(.W(SLOT_W)) u_sb_ex (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (w_freeze),
      .i_clear (w_ex_clear),
      .i_d     (w_id_entry),
      .o_q     (w_ex_q)
   );

   hazard_sb_slot #(.W(SLOT_W)) u_sb_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (w_freeze),
      .i_clear (1'b0),
      .i_d     (w_ex_q),
      .o_q     (w_mem_q)
   );

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] r_freeze_cnt;

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt  <= '0;
         r_flush_cnt  <= '0;
         r_freeze_cnt <= '0;
      end else begin
         if (w_lu_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
         if (w_freeze && (r_freeze_cnt != '1)) begin
            r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_count  = r_stall_cnt;
   assign flush_count  = r_flush_cnt;
   assign freeze_count = r_freeze_cnt;
`else
   logic [CNT_W-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: per-cycle expected control/forward vectors
// are queued with the stimulus and popped when the outputs are sampled.
module tb_hazard_ctrl;

   localparam int unsigned REG_W = 5;
`ifdef HAZARD_STATS_EN
   localparam int unsigned CNT_W = 4;
`else
   localparam int unsigned CNT_W = 16;
`endif

   // {should_stall, pc_hold, ifid_hold, ifid_flush, pipe_freeze}
   localparam logic [4:0] C0    = 5'b00000;
   localparam logic [4:0] CLU   = 5'b11100;
   localparam logic [4:0] CFL   = 5'b10010;
   localparam logic [4:0] CFZ   = 5'b11101;
   localparam logic [4:0] CFZFL = 5'b11111;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             id_reg_wrenable;
   logic [REG_W-1:0] id_write_reg;
   logic             id_mem_to_reg;
   logic             ex_is_jump;
   logic             mem_busy;
   logic             should_stall;
   logic             pc_hold;
   logic             ifid_hold;
   logic             ifid_flush;
   logic             pipe_freeze;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic [CNT_W-1:0] freeze_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid        (id_valid),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .id_reg_wrenable (id_reg_wrenable),
      .id_write_reg    (id_write_reg),
      .id_mem_to_reg   (id_mem_to_reg),
      .ex_is_jump      (ex_is_jump),
      .mem_busy        (mem_busy),
      .should_stall    (should_stall),
      .pc_hold         (pc_hold),
      .ifid_hold       (ifid_hold),
      .ifid_flush      (ifid_flush),
      .pipe_freeze     (pipe_freeze),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b)
`ifdef HAZARD_STATS_EN
      ,
      .stall_count     (stall_count),
      .flush_count     (flush_count),
      .freeze_count    (freeze_count)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [8:0] ev(input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
      return {ctl, fa, fb};
   endfunction

   // Drive the ID-stage fields for this cycle
   task automatic id(input int v, input int rs1, input int u1, input int rs2, input int u2,
                     input int we, input int rd, input int ld);
      id_valid        = 1'(v);
      id_rs1          = REG_W'(rs1);
      id_uses_rs1     = 1'(u1);
      id_rs2          = REG_W'(rs2);
      id_uses_rs2     = 1'(u2);
      id_reg_wrenable = 1'(we);
      id_write_reg    = REG_W'(rd);
      id_mem_to_reg   = 1'(ld);
   endtask

   // Queue the expectation for the inputs just driven, sample mid-cycle, advance
   task automatic cyc(input string tag, input logic [8:0] want);
      logic [8:0] got;
      exp_q.push_back(want);
      @(negedge clk);
      got = {should_stall, pc_hold, ifid_hold, ifid_flush, pipe_freeze, fwd_a, fwd_b};
      check_val(tag, 32'(got), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      ex_is_jump = 1'b0;
      mem_busy   = 1'b0;
      id(1, 5, 1, 5, 1, 1, 5, 1);
      @(posedge clk);
      #1;
      // Reset state, even with hazard-looking inputs present
      ex_is_jump = 1'b1;
      cyc("reset_busy_in", ev(C0, 2'b00, 2'b00));
      ex_is_jump = 1'b0;
      cyc("reset_hold", ev(C0, 2'b00, 2'b00));
      rst_n = 1'b1;
      id(0, 0, 0, 0, 0, 0, 0, 0);
      cyc("after_reset", ev(C0, 2'b00, 2'b00));

      // Load-use: load x5 then add reading x5
      id(1, 0, 0, 0, 0, 1, 5, 1);   cyc("lu_load",   ev(C0,  2'b00, 2'b00));
      id(1, 5, 1, 1, 1, 1, 6, 0);   cyc("lu_bubble", ev(CLU, 2'b00, 2'b00));
      cyc("lu_fwd_memwb", ev(C0, 2'b10, 2'b00));
      id(0, 0, 0, 0, 0, 0, 0, 0);   cyc("lu_drain1", ev(C0, 2'b00, 2'b00));
      cyc("lu_drain2", ev(C0, 2'b00, 2'b00));

      // ALU forwarding, EX-over-MEM priority and x0 handling
      id(1, 0, 1, 0, 0, 1, 7, 0);   cyc("alu_w7",     ev(C0, 2'b00, 2'b00));
      id(1, 2, 1, 7, 1, 1, 8, 0);   cyc("fwd_b_ex",   ev(C0, 2'b00, 2'b01));
      id(1, 3, 1, 7, 1, 1, 9, 0);   cyc("fwd_b_mem",  ev(C0, 2'b00, 2'b10));
      id(1, 8, 1, 9, 1, 0, 0, 0);   cyc("fwd_mix",    ev(C0, 2'b10, 2'b01));
      id(1, 9, 1, 0, 0, 1, 9, 0);   cyc("fwd_a_mem",  ev(C0, 2'b10, 2'b00));
      cyc("fwd_a_ex", ev(C0, 2'b01, 2'b00));
      id(1, 9, 1, 9, 1, 0, 0, 0);   cyc("fwd_prio",   ev(C0, 2'b01, 2'b01));
      id(1, 0, 0, 0, 0, 1, 0, 0);   cyc("x0_write",   ev(C0, 2'b00, 2'b00));
      id(1, 0, 1, 0, 1, 0, 0, 0);   cyc("x0_read",    ev(C0, 2'b00, 2'b00));
      id(1, 0, 0, 0, 0, 1, 0, 1);   cyc("x0_load",    ev(C0, 2'b00, 2'b00));
      id(1, 0, 1, 0, 1, 0, 0, 0);   cyc("x0_no_lu",   ev(C0, 2'b00, 2'b00));
      id(0, 0, 0, 0, 0, 0, 0, 0);   cyc("nop",        ev(C0, 2'b00, 2'b00));

      // Jump squash: two flush cycles then back to RUN
      ex_is_jump = 1'b1;            cyc("jmp_run",    ev(CFL, 2'b00, 2'b00));
      ex_is_jump = 1'b0;            cyc("jmp_flush",  ev(CFL, 2'b00, 2'b00));
      cyc("jmp_done", ev(C0, 2'b00, 2'b00));

      // Memory freeze on top of a load-use hazard
      id(1, 0, 0, 0, 0, 1, 5, 1);   cyc("fz_load",    ev(C0, 2'b00, 2'b00));
      id(1, 5, 1, 1, 1, 1, 6, 0);
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc($sformatf("fz_busy%0d", i), ev(CFZ, 2'b00, 2'b00));
      end
      mem_busy = 1'b0;              cyc("fz_release_lu", ev(CLU, 2'b00, 2'b00));
      cyc("fz_fwd_memwb", ev(C0, 2'b10, 2'b00));
      id(0, 0, 0, 0, 0, 0, 0, 0);   cyc("fz_drain1",  ev(C0, 2'b00, 2'b00));
      cyc("fz_drain2", ev(C0, 2'b00, 2'b00));

      // Jump and load-use together: flush sequence only
      id(1, 0, 0, 0, 0, 1, 5, 1);   cyc("jl_load",    ev(C0, 2'b00, 2'b00));
      id(1, 5, 1, 1, 1, 1, 6, 0);
      ex_is_jump = 1'b1;            cyc("jl_jump",    ev(CFL, 2'b00, 2'b00));
      ex_is_jump = 1'b0;            cyc("jl_flush",   ev(CFL, 2'b10, 2'b00));
      id(0, 0, 0, 0, 0, 0, 0, 0);   cyc("jl_done",    ev(C0, 2'b00, 2'b00));

      // Reset while in FLUSH
      ex_is_jump = 1'b1;            cyc("rf_jump",    ev(CFL, 2'b00, 2'b00));
      ex_is_jump = 1'b0;
      rst_n = 1'b0;                 cyc("rf_reset",   ev(C0, 2'b00, 2'b00));
      rst_n = 1'b1;                 cyc("rf_run",     ev(C0, 2'b00, 2'b00));

      // Jump arriving with a freeze is serviced on release
      ex_is_jump = 1'b1;
      mem_busy   = 1'b1;            cyc("jf_freeze",  ev(CFZ, 2'b00, 2'b00));
      mem_busy   = 1'b0;            cyc("jf_exit",    ev(CFL, 2'b00, 2'b00));
      ex_is_jump = 1'b0;            cyc("jf_flush",   ev(CFL, 2'b00, 2'b00));
      cyc("jf_done", ev(C0, 2'b00, 2'b00));

      // Memory stall arriving during FLUSH
      ex_is_jump = 1'b1;            cyc("fb_jump",    ev(CFL,   2'b00, 2'b00));
      ex_is_jump = 1'b0;
      mem_busy   = 1'b1;            cyc("fb_flushfz", ev(CFZFL, 2'b00, 2'b00));
      mem_busy   = 1'b0;            cyc("fb_exit",    ev(C0,    2'b00, 2'b00));
      cyc("fb_done", ev(C0, 2'b00, 2'b00));

`ifdef HAZARD_STATS_EN
      // Counter saturation after 20 load-use bubbles
      rst_n = 1'b0;                 cyc("st_reset",   ev(C0, 2'b00, 2'b00));
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         id(1, 0, 0, 0, 0, 1, 5, 1); cyc("st_load",   ev(C0,  2'b00, 2'b00));
         id(1, 5, 1, 0, 0, 1, 6, 0); cyc("st_bubble", ev(CLU, 2'b00, 2'b00));
      end
      check_val("stall_count_sat", 32'(stall_count),  32'd15);
      check_val("flush_count",     32'(flush_count),  32'd0);
      check_val("freeze_count",    32'(freeze_count), 32'd0);
`endif

      if (exp_q.size() != 0) begin
         check_val("queue_empty", 32'(exp_q.size()), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
